// File: rtl/panel_pkg.sv
// Shared constants for the operator-panel front end: input bit maps,
// run-FSM encoding and datapath widths.
package panel_pkg;

  localparam int C_W    = 31;
  localparam int ADDR_W = 12;

  localparam int N_BTN = 8;
  localparam int N_SW  = 6;
  localparam int N_IN  = N_BTN + N_SW;

  localparam int BTN_MACHINE_START    = 0;
  localparam int BTN_CLEAR_PULSE      = 1;
  localparam int BTN_DO_READ_MEM      = 2;
  localparam int BTN_DO_WRITE_MEM     = 3;
  localparam int BTN_WRITE_REG        = 4;
  localparam int BTN_CLEAR_REG_C      = 5;
  localparam int BTN_CLEAR_REG_SELECT = 6;
  localparam int BTN_CLEAR_REG_START  = 7;

  localparam int SW_AUTO_ENABLE     = 0;
  localparam int SW_STOP_AT_ENABLE  = 1;
  localparam int SW_SELECT_OR_START = 2;
  localparam int SW_ARR_REG_C       = 3;
  localparam int SW_ARR_REG_SELECT  = 4;
  localparam int SW_ARR_REG_START   = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  // One arrange request for a single register: strobe plus data.
  typedef struct packed {
    logic             strobe;
    logic [C_W-1:0]   data;
  } arr_req_t;

  // Resolves clear/write for one register; clear always beats write.
  function automatic arr_req_t arr_resolve(input logic clr, input logic wr,
                                           input logic sel,
                                           input logic [C_W-1:0] value);
    arr_req_t r;
    r.strobe = 1'b0;
    r.data   = '0;
    if (clr) begin
      r.strobe = 1'b1;
    end else if (wr && sel) begin
      r.strobe = 1'b1;
      r.data   = value;
    end
    return r;
  endfunction

endpackage

// File: rtl/panel_debounce.sv
// Single-input conditioner: two-flop synchroniser, stability counter and
// debounced level, plus a one-cycle pulse on each debounced rising edge.
module panel_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        // This sample is the DEBOUNCE_CYCLES-th consecutive disagreement.
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_rise  <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/panel_ctrl.sv
// Operator-panel front end: conditions buttons/switches, produces command
// pulses and arrange strobes, and runs the instruction start sequencer.
module panel_ctrl
  import panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_BTN-1:0]  raw_btn,
  input  logic [N_SW-1:0]   raw_sw,
  input  logic [C_W-1:0]    input_reg_c_value,
  input  logic [ADDR_W-1:0] input_reg_select_value,
  input  logic [ADDR_W-1:0] input_reg_start_value,
  input  logic [ADDR_W-1:0] reg_start_value,
  input  logic [ADDR_W-1:0] stop_addr,
  input  logic              instr_done,
  output logic              start_pulse,
  output logic              clear_pulse,
  output logic              do_read_mem,
  output logic              do_write_mem,
  output logic              do_arr_reg_c,
  output logic              do_arr_reg_select,
  output logic              do_arr_reg_start,
  output logic [C_W-1:0]    arr_reg_c_data,
  output logic [ADDR_W-1:0] arr_reg_select_data,
  output logic [ADDR_W-1:0] arr_reg_start_data,
  output logic [N_SW-1:0]   sw_level,
  output logic              running
);

  logic [N_IN-1:0]   w_raw;
  logic [N_IN-1:0]   w_level;
  logic [N_IN-1:0]   w_rise;
  logic [N_BTN-1:0]  w_btn_rise;
  logic [N_SW-1:0]   w_sw_level;
  logic              w_unused;

  assign w_raw      = {raw_sw, raw_btn};
  assign w_btn_rise = w_rise[N_BTN-1:0];
  assign w_sw_level = w_level[N_IN-1:N_BTN];
  // Button levels and switch edges are produced by the shared conditioner
  // but have no consumer here.
  assign w_unused   = ^{w_level[N_BTN-1:0], w_rise[N_IN-1:N_BTN]};

  for (genvar g = 0; g < N_IN; g++) begin : g_cond
    panel_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (w_raw[g]),
      .o_level (w_level[g]),
      .o_rise  (w_rise[g])
    );
  end

  // Arrange requests, resolved with clear-over-write priority.
  arr_req_t w_arr_c;
  arr_req_t w_arr_sel;
  arr_req_t w_arr_st;

  always_comb begin
    w_arr_c   = arr_resolve(w_btn_rise[BTN_CLEAR_REG_C], w_btn_rise[BTN_WRITE_REG],
                            w_sw_level[SW_ARR_REG_C], input_reg_c_value);
    w_arr_sel = arr_resolve(w_btn_rise[BTN_CLEAR_REG_SELECT], w_btn_rise[BTN_WRITE_REG],
                            w_sw_level[SW_ARR_REG_SELECT],
                            {{(C_W-ADDR_W){1'b0}}, input_reg_select_value});
    w_arr_st  = arr_resolve(w_btn_rise[BTN_CLEAR_REG_START], w_btn_rise[BTN_WRITE_REG],
                            w_sw_level[SW_ARR_REG_START],
                            {{(C_W-ADDR_W){1'b0}}, input_reg_start_value});
  end

  logic              r_clear_pulse;
  logic              r_do_read_mem;
  logic              r_do_write_mem;
  logic              r_do_arr_c;
  logic              r_do_arr_sel;
  logic              r_do_arr_st;
  logic [C_W-1:0]    r_arr_c_data;
  logic [ADDR_W-1:0] r_arr_sel_data;
  logic [ADDR_W-1:0] r_arr_st_data;
  logic [N_SW-1:0]   r_sw_level;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clear_pulse  <= 1'b0;
      r_do_read_mem  <= 1'b0;
      r_do_write_mem <= 1'b0;
      r_do_arr_c     <= 1'b0;
      r_do_arr_sel   <= 1'b0;
      r_do_arr_st    <= 1'b0;
      r_arr_c_data   <= '0;
      r_arr_sel_data <= '0;
      r_arr_st_data  <= '0;
      r_sw_level     <= '0;
    end else begin
      r_clear_pulse  <= w_btn_rise[BTN_CLEAR_PULSE];
      r_do_read_mem  <= w_btn_rise[BTN_DO_READ_MEM];
      r_do_write_mem <= w_btn_rise[BTN_DO_WRITE_MEM];
      r_do_arr_c     <= w_arr_c.strobe;
      r_do_arr_sel   <= w_arr_sel.strobe;
      r_do_arr_st    <= w_arr_st.strobe;
      r_arr_c_data   <= w_arr_c.data;
      r_arr_sel_data <= w_arr_sel.data[ADDR_W-1:0];
      r_arr_st_data  <= w_arr_st.data[ADDR_W-1:0];
      r_sw_level     <= w_sw_level;
    end
  end

  // Run sequencer. The clear button is taken from the conditioner edge
  // directly so that it can override a same-cycle start or done.
  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic       w_stop;

  assign w_stop = w_sw_level[SW_STOP_AT_ENABLE] && (reg_start_value == stop_addr);

  always_comb begin
    w_state_next = r_state;
    if (w_btn_rise[BTN_CLEAR_PULSE]) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_btn_rise[BTN_MACHINE_START]) w_state_next = ST_ISSUE;
        ST_ISSUE: w_state_next = ST_WAIT;
        ST_WAIT: begin
          if (instr_done) begin
            w_state_next = (w_sw_level[SW_AUTO_ENABLE] && !w_stop) ? ST_ISSUE : ST_IDLE;
          end
        end
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  assign start_pulse         = (r_state == ST_ISSUE);
  assign running             = (r_state != ST_IDLE);
  assign clear_pulse         = r_clear_pulse;
  assign do_read_mem         = r_do_read_mem;
  assign do_write_mem        = r_do_write_mem;
  assign do_arr_reg_c        = r_do_arr_c;
  assign do_arr_reg_select   = r_do_arr_sel;
  assign do_arr_reg_start    = r_do_arr_st;
  assign arr_reg_c_data      = r_arr_c_data;
  assign arr_reg_select_data = r_arr_sel_data;
  assign arr_reg_start_data  = r_arr_st_data;
  assign sw_level            = r_sw_level;

endmodule

// File: tb/tb_panel_ctrl.sv
// Directed bench for panel_ctrl with DEBOUNCE_CYCLES=4: expected output
// events (cycle stamp + all strobes/data) are queued and matched by a monitor.
module tb_panel_ctrl;

  localparam int EW = 94;

  localparam logic [6:0] S_START = 7'b1000000;
  localparam logic [6:0] S_CLR   = 7'b0100000;
  localparam logic [6:0] S_RD    = 7'b0010000;
  localparam logic [6:0] S_WR    = 7'b0001000;
  localparam logic [6:0] S_AC    = 7'b0000100;
  localparam logic [6:0] S_AS    = 7'b0000010;
  localparam logic [6:0] S_AT    = 7'b0000001;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  raw_btn;
  logic [5:0]  raw_sw;
  logic [30:0] input_reg_c_value;
  logic [11:0] input_reg_select_value;
  logic [11:0] input_reg_start_value;
  logic [11:0] reg_start_value;
  logic [11:0] stop_addr;
  logic        instr_done;
  logic        start_pulse, clear_pulse, do_read_mem, do_write_mem;
  logic        do_arr_reg_c, do_arr_reg_select, do_arr_reg_start;
  logic [30:0] arr_reg_c_data;
  logic [11:0] arr_reg_select_data, arr_reg_start_data;
  logic [5:0]  sw_level;
  logic        running;

  logic        man_done;
  logic        core_done;
  logic [11:0] core_val;
  logic        core_auto;
  int          core_idx;
  logic [11:0] core_tbl [3];

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];

  assign instr_done      = man_done | core_done;
  assign reg_start_value = core_val;

  panel_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .raw_btn                (raw_btn),
    .raw_sw                 (raw_sw),
    .input_reg_c_value      (input_reg_c_value),
    .input_reg_select_value (input_reg_select_value),
    .input_reg_start_value  (input_reg_start_value),
    .reg_start_value        (reg_start_value),
    .stop_addr              (stop_addr),
    .instr_done             (instr_done),
    .start_pulse            (start_pulse),
    .clear_pulse            (clear_pulse),
    .do_read_mem            (do_read_mem),
    .do_write_mem           (do_write_mem),
    .do_arr_reg_c           (do_arr_reg_c),
    .do_arr_reg_select      (do_arr_reg_select),
    .do_arr_reg_start       (do_arr_reg_start),
    .arr_reg_c_data         (arr_reg_c_data),
    .arr_reg_select_data    (arr_reg_select_data),
    .arr_reg_start_data     (arr_reg_start_data),
    .sw_level               (sw_level),
    .running                (running)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic logic [EW-1:0] mk_ev(input int cy, input logic [6:0] s,
                                          input logic [30:0] c, input logic [11:0] sel,
                                          input logic [11:0] st);
    return {32'(cy), s, c, sel, st};
  endfunction

  task automatic push_ev(input int cy, input logic [6:0] s, input logic [30:0] c,
                         input logic [11:0] sel, input logic [11:0] st);
    exp_q.push_back(mk_ev(cy, s, c, sel, st));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold_btn(input logic [7:0] mask, input int n);
    raw_btn = raw_btn | mask;
    tick(n);
    raw_btn = raw_btn & ~mask;
  endtask

  task automatic pulse_done();
    man_done = 1'b1;
    tick(1);
    man_done = 1'b0;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (cyc %0d)", name, got, req, cyc);
    end
  endtask

  // Scoreboard monitor: every cycle with any strobe high must match the queue head.
  always @(negedge clk) begin
    logic [EW-1:0] got;
    logic [EW-1:0] req;
    if (start_pulse | clear_pulse | do_read_mem | do_write_mem |
        do_arr_reg_c | do_arr_reg_select | do_arr_reg_start) begin
      got = mk_ev(cyc, {start_pulse, clear_pulse, do_read_mem, do_write_mem,
                        do_arr_reg_c, do_arr_reg_select, do_arr_reg_start},
                  arr_reg_c_data, arr_reg_select_data, arr_reg_start_data);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: got %0h required no event", got);
      end else begin
        req = exp_q.pop_front();
        if (got !== req) begin
          n_err++;
          $display("FAIL event: got %0h required %0h", got, req);
        end
      end
    end
  end

  // Core model: answers each start_pulse with instr_done five cycles later.
  initial begin
    core_done = 1'b0;
    core_val  = '0;
    core_idx  = 0;
    core_tbl  = '{12'h00E, 12'h00F, 12'h010};
    forever begin
      @(negedge clk);
      if (start_pulse && core_auto) begin
        repeat (4) @(posedge clk);
        #1;
        core_done = 1'b1;
        core_val  = core_tbl[core_idx % 3];
        core_idx++;
        @(posedge clk);
        #1;
        core_done = 1'b0;
      end
    end
  end

  // Stimulus
  initial begin
    int k;
    reset = 1'b1;
    raw_btn = '0;
    raw_sw = '0;
    input_reg_c_value = '0;
    input_reg_select_value = '0;
    input_reg_start_value = '0;
    stop_addr = '0;
    man_done = 1'b0;
    core_auto = 1'b0;
    tick(3);
    chk("reset_ctrl", 64'({start_pulse, clear_pulse, do_read_mem, do_write_mem,
        do_arr_reg_c, do_arr_reg_select, do_arr_reg_start, running, sw_level}), 64'd0);
    chk("reset_data", 64'({arr_reg_c_data, arr_reg_select_data, arr_reg_start_data}), 64'd0);
    reset = 1'b0;
    tick(2);

    // Debounce latency: read_mem pulse 7 cycles after first sampled 1
    push_ev(cyc + 7, S_RD, '0, '0, '0);
    hold_btn(8'h04, 10);
    tick(12);
    // 3-cycle glitch must not produce a pulse
    hold_btn(8'h04, 3);
    tick(12);
    push_ev(cyc + 7, S_WR, '0, '0, '0);
    hold_btn(8'h08, 10);
    tick(12);

    // Arrange with C and start selected, select not selected
    raw_sw = 6'b101000;
    input_reg_c_value      = 31'h12345678;
    input_reg_select_value = 12'h3C3;
    input_reg_start_value  = 12'h0A5;
    tick(10);
    chk("sw_level_arr", 64'(sw_level), 64'(6'b101000));
    push_ev(cyc + 7, S_AC | S_AT, 31'h12345678, '0, 12'h0A5);
    hold_btn(8'h10, 10);
    tick(12);
    // write_reg together with clear_reg_c: clear wins for C
    push_ev(cyc + 7, S_AC | S_AT, '0, '0, 12'h0A5);
    hold_btn(8'h30, 10);
    tick(12);
    // clear_reg_select strobes even though its arrange switch is off
    push_ev(cyc + 7, S_AS, '0, '0, '0);
    hold_btn(8'h40, 10);
    tick(12);

    // Single step
    push_ev(cyc + 7, S_START, '0, '0, '0);
    hold_btn(8'h01, 10);
    chk("running_wait", 64'(running), 64'd1);
    pulse_done();
    chk("running_after_done", 64'(running), 64'd0);
    tick(12);

    // Auto run with stop-at
    raw_sw = 6'b101011;
    stop_addr = 12'h010;
    tick(10);
    chk("sw_level_auto", 64'(sw_level), 64'(6'b101011));
    core_auto = 1'b1;
    k = cyc;
    push_ev(k + 7, S_START, '0, '0, '0);
    push_ev(k + 12, S_START, '0, '0, '0);
    push_ev(k + 17, S_START, '0, '0, '0);
    hold_btn(8'h01, 10);
    chk("running_auto", 64'(running), 64'd1);
    tick(15);
    chk("running_stop", 64'(running), 64'd0);
    chk("core_done_count", 64'(core_idx), 64'd3);
    core_auto = 1'b0;
    tick(5);

    // Abort with clear button during WAIT
    push_ev(cyc + 7, S_START, '0, '0, '0);
    hold_btn(8'h01, 10);
    tick(12);
    chk("running_pre_abort", 64'(running), 64'd1);
    k = cyc;
    push_ev(k + 7, S_CLR, '0, '0, '0);
    raw_btn[1] = 1'b1;
    tick(6);
    chk("running_clear_edge", 64'(running), 64'd1);
    tick(1);
    chk("running_aborted", 64'(running), 64'd0);
    tick(3);
    raw_btn[1] = 1'b0;
    pulse_done();
    tick(12);
    chk("running_after_stale_done", 64'(running), 64'd0);

    // Reset in the middle of WAIT
    push_ev(cyc + 7, S_START, '0, '0, '0);
    hold_btn(8'h01, 10);
    chk("running_pre_reset", 64'(running), 64'd1);
    reset = 1'b1;
    tick(1);
    chk("midreset_ctrl", 64'({start_pulse, clear_pulse, do_read_mem, do_write_mem,
        do_arr_reg_c, do_arr_reg_select, do_arr_reg_start, running, sw_level}), 64'd0);
    chk("midreset_data", 64'({arr_reg_c_data, arr_reg_select_data, arr_reg_start_data}), 64'd0);
    reset = 1'b0;
    pulse_done();
    tick(10);
    chk("running_post_reset", 64'(running), 64'd0);
    chk("sw_level_post_reset", 64'(sw_level), 64'(6'b101011));

    tick(5);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/panel_ctrl.md
Name: panel_ctrl

Overview:
- Operator-panel front end sitting directly upstream of core_top.
- Synchronises and debounces raw panel buttons and switches, then turns button presses into single-cycle command pulses.
- Sequences manual register arrangement (C / select / start) from the panel input switches.
- Runs the machine-run FSM that issues per-instruction start pulses to the pulse unit, with auto-run and stop-at-address support.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised samples needed before a debounced level changes; legal range 2..65535.
- CNT_W, 16: width of each debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- raw_btn  in  8  raw buttons, active-high. Bit map: [0] machine_start, [1] clear_pulse, [2] do_read_mem, [3] do_write_mem, [4] write_reg, [5] clear_reg_c, [6] clear_reg_select, [7] clear_reg_start
- raw_sw  in  6  raw switches. Bit map: [0] auto_enable, [1] stop_at_enable, [2] select_or_start, [3] arr_reg_c, [4] arr_reg_select, [5] arr_reg_start
- input_reg_c_value  in  31  panel value for register C
- input_reg_select_value  in  12  panel value for the select register
- input_reg_start_value  in  12  panel value for the start register
- reg_start_value  in  12  current start-register value from the core
- stop_addr  in  12  stop-at comparison address
- instr_done  in  1  one-cycle pulse from the core marking the end of an instruction
- start_pulse  out  1  one-cycle instruction start to the pulse unit
- clear_pulse  out  1  one-cycle pulse-counter clear
- do_read_mem, do_write_mem  out  1 each  one-cycle manual memory access requests
- do_arr_reg_c / do_arr_reg_select / do_arr_reg_start  out  1 each  one-cycle arrange strobes
- arr_reg_c_data  out  31  data accompanying do_arr_reg_c
- arr_reg_select_data  out  12  data accompanying do_arr_reg_select
- arr_reg_start_data  out  12  data accompanying do_arr_reg_start
- sw_level  out  6  debounced switch levels
- running  out  1  high while the run FSM is not in IDLE

Behaviour:
- Reset (synchronous): all pulse and strobe outputs 0; all data outputs 0; running 0; FSM in IDLE.
  - Debounce counters 0; synchroniser flops 0; debounced levels 0.
  - This applies mid-operation too: an outstanding instruction is abandoned and a later instr_done is ignored.
- Input conditioning, identical for all 14 inputs:
  - Two-flop synchroniser feeds a per-input counter.
  - The counter increments while the synchronised level differs from the debounced level and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- Button pulses:
  - A button pulse is high for exactly one cycle, the cycle after the debounced rising edge.
  - Total latency from the first edge sampling a raw 1 to the pulse is DEBOUNCE_CYCLES+3 cycles.
  - Releasing a button produces no pulse.
- do_read_mem, do_write_mem and clear_pulse are the corresponding button pulses, passed through registered.
- Arrange logic (registered; strobe and data in the same cycle):
  - write_reg pulse: for each register whose debounced arr switch is 1, do_arr_X=1 and arr_X_data = input_reg_X_value.
  - clear_reg_X pulse: do_arr_X=1 and arr_X_data=0, regardless of the arr switch.
  - Clear and write for the same register in the same cycle: clear wins.
  - Data outputs are 0 whenever their strobe is 0.
- Run FSM, states IDLE, ISSUE, WAIT:
  - IDLE: on machine_start pulse -> ISSUE.
  - ISSUE: start_pulse=1 for one cycle -> WAIT.
  - WAIT: on instr_done, stop = stop_at_enable && (reg_start_value == stop_addr), using the value present in the instr_done cycle.
    - If auto_enable && !stop -> ISSUE; otherwise -> IDLE.
  - machine_start pulse while in ISSUE or WAIT is ignored.
  - instr_done while in IDLE or ISSUE is ignored.
  - clear_pulse (button) in any state forces IDLE next cycle. It has priority over instr_done and machine_start in the same cycle.
  - Minimum gap between successive start_pulses is 2 cycles (instr_done -> ISSUE -> pulse).
- running = (state != IDLE).
- sw_level is the registered debounced switch state.
- select_or_start is conditioned and exported only; it has no internal effect.

Decomposition:
- Shared package panel_pkg holds:
  - button and switch bit-index constants;
  - FSM state encoding (2-bit: IDLE=0, ISSUE=1, WAIT=2);
  - value widths (C=31, ADDR=12).
- One natural sub-module: panel_debounce. It contains a synchroniser, counter and debounced level for a single input, is parameterised by DEBOUNCE_CYCLES, and produces level and rise outputs. It is instantiated 14 times via generate.

Test Plan (DEBOUNCE_CYCLES=4):
- Debounce timing: raw_btn[2] held high 10 cycles -> do_read_mem high exactly once, at cycle 7 after the first sampled 1. A 3-cycle glitch on raw_btn[2] -> no pulse.
- Arrange: arr_reg_c=1, arr_reg_start=1, arr_reg_select=0; input_reg_c_value=31'h12345678, input_reg_start_value=12'h0A5; press write_reg -> one cycle with do_arr_reg_c=1 / data 31'h12345678 and do_arr_reg_start=1 / data 12'h0A5; do_arr_reg_select=0.
- Clear vs write collision: press write_reg and clear_reg_c together with arr_reg_c=1 -> do_arr_reg_c=1 with arr_reg_c_data=0.
- Single step: auto=0; press machine_start -> one start_pulse, running=1. instr_done -> running=0 and no further start_pulse.
- Auto with stop-at: auto=1, stop_at=1, stop_addr=12'h010. Core answers each start_pulse with instr_done 5 cycles later, with reg_start_value stepping 12'h00E, 12'h00F, 12'h010 -> exactly 3 start_pulses, then IDLE.
- Abort and reset: during WAIT, press clear_pulse -> clear_pulse=1 one cycle, IDLE next cycle; a later instr_done issues nothing. Assert reset mid-WAIT -> all outputs 0 the next cycle.
